// File: rtl/copy_sched_pkg.sv
// Shared constants and FSM encoding for the copy scheduler.
package copy_sched_pkg;
    localparam int PKT_IN_W  = 40;
    localparam int PKT_OUT_W = 38;

    localparam int DEST_LSB = 22;
    localparam int DEST_MSB = 28;
    localparam int LRO_BIT  = 21;
    localparam int LRC_BIT  = 20;
    localparam int CPY_BIT  = 18;

    localparam int DEST_W_DEF = DEST_MSB - DEST_LSB + 1;

    typedef enum logic [1:0] {
        IDLE,
        ACK_IN,
        SEND,
        SEND_RTZ
    } state_e;
endpackage

// File: rtl/copy_sched_if.sv
// Four-phase Send/Ack bundle: two requesters in, one next-node link out.
interface copy_sched_if;
    import copy_sched_pkg::*;

    logic                 Send_in_a;
    logic [PKT_IN_W-1:0]  PACKET_IN_a;
    logic                 Ack_out_a;
    logic                 Send_in_b;
    logic [PKT_IN_W-1:0]  PACKET_IN_b;
    logic                 Ack_out_b;
    logic                 Send_out;
    logic                 Ack_in;
    logic [PKT_OUT_W-1:0] PACKET_OUT;

    modport master (
        output Send_in_a, PACKET_IN_a, Send_in_b, PACKET_IN_b, Ack_in,
        input  Ack_out_a, Ack_out_b, Send_out, PACKET_OUT
    );

    modport slave (
        input  Send_in_a, PACKET_IN_a, Send_in_b, PACKET_IN_b, Ack_in,
        output Ack_out_a, Ack_out_b, Send_out, PACKET_OUT
    );
endinterface

// File: rtl/copy_sched_rr.sv
// Two-requester round-robin grant; pointer flips only on a contested grant.
module copy_sched_rr (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic req_a_i,
    input  logic req_b_i,
    output logic gnt_vld_o,
    output logic gnt_b_o
);
    logic rr_q, rr_d;   // 0: A wins a tie, 1: B wins a tie

    always_comb begin
        gnt_vld_o = en_i && (req_a_i || req_b_i);
        gnt_b_o   = req_b_i && (!req_a_i || rr_q);
        rr_d      = rr_q;
        if (en_i && req_a_i && req_b_i)
            rr_d = ~rr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rr_q <= 1'b0;
        else        rr_q <= rr_d;
    end
endmodule

// File: rtl/copy_sched.sv
// Copy controller + two-port arbiter; emits the packet, then its dest+1 copy when CPY is set.
// Optional COPY_SCHED_SYNC_EN: 2-flop synchronizers on Send_in_a/b and Ack_in.
module copy_sched
    import copy_sched_pkg::*;
#(
    parameter int DEST_W = DEST_W_DEF,
    parameter int CNT_W  = 16
) (
    input  logic             CLK,
    input  logic             MR_N,
    copy_sched_if.slave      bus,
    output logic [CNT_W-1:0] copy_cnt,
    output logic             busy
);
    logic send_a_s, send_b_s, ack_s;

`ifdef COPY_SCHED_SYNC_EN
    logic [2:0] sync1_q, sync2_q;
    always_ff @(posedge CLK or negedge MR_N) begin
        if (!MR_N) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {bus.Ack_in, bus.Send_in_b, bus.Send_in_a};
            sync2_q <= sync1_q;
        end
    end
    assign {ack_s, send_b_s, send_a_s} = sync2_q;
`else
    assign send_a_s = bus.Send_in_a;
    assign send_b_s = bus.Send_in_b;
    assign ack_s    = bus.Ack_in;
`endif

    state_e               state_q, state_d;
    logic [PKT_OUT_W-1:0] dl_q, dl_d;       // input bits 39:38 are never stored
    logic                 gnt_b_q, gnt_b_d;
    logic                 cp_q, cp_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 gnt_vld, gnt_b;

    copy_sched_rr u_rr (
        .clk       (CLK),
        .rst_n     (MR_N),
        .en_i      (state_q == IDLE),
        .req_a_i   (send_a_s),
        .req_b_i   (send_b_s),
        .gnt_vld_o (gnt_vld),
        .gnt_b_o   (gnt_b)
    );

    always_comb begin
        state_d = state_q;
        dl_d    = dl_q;
        gnt_b_d = gnt_b_q;
        cp_d    = cp_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (gnt_vld) begin
                dl_d    = gnt_b ? bus.PACKET_IN_b[PKT_OUT_W-1:0]
                                : bus.PACKET_IN_a[PKT_OUT_W-1:0];
                gnt_b_d = gnt_b;
                cp_d    = 1'b0;
                state_d = ACK_IN;
            end
            ACK_IN: if (!(gnt_b_q ? send_b_s : send_a_s))
                state_d = SEND;
            SEND: if (ack_s)
                state_d = SEND_RTZ;
            SEND_RTZ: if (!ack_s) begin
                if (dl_q[CPY_BIT] && !cp_q) begin
                    cp_d    = 1'b1;
                    state_d = SEND;
                    if (cnt_q != '1)
                        cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge MR_N) begin
        if (!MR_N) begin
            state_q <= IDLE;
            dl_q    <= '0;
            gnt_b_q <= 1'b0;
            cp_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            dl_q    <= dl_d;
            gnt_b_q <= gnt_b_d;
            cp_q    <= cp_d;
            cnt_q   <= cnt_d;
        end
    end

    // PACKET_OUT depends only on dl_q/cp_q, which move only when Send_out is low.
    logic [DEST_W-1:0] dest, dsel;
    logic              lsel;
    assign dest = dl_q[DEST_LSB +: DEST_W];
    assign dsel = cp_q ? dest + DEST_W'(1) : dest;
    assign lsel = cp_q ? dl_q[LRC_BIT] : dl_q[LRO_BIT];

    assign bus.PACKET_OUT = {dl_q[PKT_OUT_W-1:DEST_W+LRC_BIT], dsel, lsel,
                             dl_q[19], dl_q[17:0]};
    assign bus.Ack_out_a  = (state_q == ACK_IN) && !gnt_b_q;
    assign bus.Ack_out_b  = (state_q == ACK_IN) &&  gnt_b_q;
    assign bus.Send_out   = (state_q == SEND);
    assign busy           = (state_q != IDLE);
    assign copy_cnt       = cnt_q;

    logic unused_msbs;
    assign unused_msbs = ^{bus.PACKET_IN_a[PKT_IN_W-1:PKT_OUT_W],
                           bus.PACKET_IN_b[PKT_IN_W-1:PKT_OUT_W]};
endmodule

// File: tb/tb_copy_sched.sv
// Directed bench for copy_sched: reset, single, copy, wrap, contention, mid-op reset.
module tb_copy_sched;
    logic        CLK = 1'b0;
    logic        MR_N = 1'b0;
    logic [15:0] copy_cnt;
    logic        busy;
    int          n_cmp = 0;
    int          n_err = 0;
    bit          both_seen = 1'b0;

    copy_sched_if bus ();

    copy_sched dut (
        .CLK      (CLK),
        .MR_N     (MR_N),
        .bus      (bus.slave),
        .copy_cnt (copy_cnt),
        .busy     (busy)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) if (bus.Ack_out_a && bus.Ack_out_b) both_seen = 1'b1;

    function automatic logic [39:0] mk(input logic [6:0] d, input bit lro, input bit lrc,
                                       input bit cpy, input logic [15:0] tag);
        logic [39:0] p;
        p = 40'hC5_A5A5_A5A5 ^ {24'h0, tag};
        p[28:22] = d;
        p[21] = lro;
        p[20] = lrc;
        p[18] = cpy;
        return p;
    endfunction

    // Reference output format from the packet definition
    function automatic logic [37:0] exp_out(input logic [39:0] p, input bit cp);
        logic [6:0] d;
        d = cp ? p[28:22] + 7'd1 : p[28:22];
        return {p[37:27], d, (cp ? p[20] : p[21]), p[19], p[17:0]};
    endfunction

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic req(input bit b, input logic [39:0] p, input string nm);
        int t;
        if (b) begin bus.PACKET_IN_b = p; bus.Send_in_b = 1'b1; end
        else   begin bus.PACKET_IN_a = p; bus.Send_in_a = 1'b1; end
        t = 0;
        do begin tick(); t++; end
        while (!(b ? bus.Ack_out_b : bus.Ack_out_a) && t < 20);
        n_cmp++;
        if ((b ? bus.Ack_out_b : bus.Ack_out_a) !== 1'b1) begin
            n_err++; $display("FAIL %s ack_rise: got 0 want 1", nm);
        end
        if (b) bus.Send_in_b = 1'b0; else bus.Send_in_a = 1'b0;
        t = 0;
        while ((b ? bus.Ack_out_b : bus.Ack_out_a) && t < 20) begin tick(); t++; end
        n_cmp++;
        if ((b ? bus.Ack_out_b : bus.Ack_out_a) !== 1'b0) begin
            n_err++; $display("FAIL %s ack_fall: got 1 want 0", nm);
        end
    endtask

    task automatic recv(input logic [37:0] exp, input string nm);
        int t;
        t = 0;
        while (bus.Send_out !== 1'b1 && t < 20) begin tick(); t++; end
        n_cmp++;
        if (bus.Send_out !== 1'b1 || bus.PACKET_OUT !== exp) begin
            n_err++;
            $display("FAIL %s pkt: send=%b got %h want %h", nm, bus.Send_out, bus.PACKET_OUT, exp);
        end
        bus.Ack_in = 1'b1;
        t = 0;
        do begin tick(); t++; end while (bus.Send_out && t < 20);
        n_cmp++;
        if (bus.Send_out !== 1'b0 || bus.PACKET_OUT !== exp) begin
            n_err++;
            $display("FAIL %s rtz: send=%b got %h want %h", nm, bus.Send_out, bus.PACKET_OUT, exp);
        end
        bus.Ack_in = 1'b0;
        tick();
    endtask

    task automatic quiet(input int n, input string nm);
        int hits;
        hits = 0;
        repeat (n) begin if (bus.Send_out) hits++; tick(); end
        n_cmp++;
        if (hits !== 0) begin n_err++; $display("FAIL %s extra_send: got %0d want 0", nm, hits); end
    endtask

    task automatic test_reset();
        logic [39:0] p;
        int t;
        p = mk(7'd3, 1'b0, 1'b0, 1'b0, 16'h1111);
        MR_N = 1'b0;
        bus.PACKET_IN_a = p;
        bus.Send_in_a = 1'b1;
        tick(); tick();
        n_cmp++;
        if ({bus.Ack_out_a, bus.Ack_out_b, bus.Send_out, busy} !== 4'b0) begin
            n_err++; $display("FAIL reset_ctl: got %b want 0000",
                              {bus.Ack_out_a, bus.Ack_out_b, bus.Send_out, busy});
        end
        n_cmp++;
        if (bus.PACKET_OUT !== 38'h0 || copy_cnt !== 16'h0) begin
            n_err++; $display("FAIL reset_data: pkt %h cnt %h want 0 0", bus.PACKET_OUT, copy_cnt);
        end
        MR_N = 1'b1;
        tick();
        n_cmp++;
        if (bus.Ack_out_a !== 1'b1) begin
            n_err++; $display("FAIL reset_first_ack: got %b want 1", bus.Ack_out_a);
        end
        bus.Send_in_a = 1'b0;
        t = 0;
        while (bus.Ack_out_a && t < 20) begin tick(); t++; end
        recv(exp_out(p, 1'b0), "reset_pkt");
        quiet(4, "reset");
    endtask

    task automatic test_single();
        logic [39:0] p;
        p = mk(7'd5, 1'b1, 1'b0, 1'b0, 16'h1234);
        req(1'b0, p, "single");
        recv(exp_out(p, 1'b0), "single");
        n_cmp++;
        if (bus.PACKET_OUT[26:20] !== 7'd5 || bus.PACKET_OUT[19] !== 1'b1) begin
            n_err++; $display("FAIL single_fields: dest %0d lr %b want 5 1",
                              bus.PACKET_OUT[26:20], bus.PACKET_OUT[19]);
        end
        quiet(6, "single");
        n_cmp++;
        if (copy_cnt !== 16'd0) begin n_err++; $display("FAIL single_cnt: got %0d want 0", copy_cnt); end
    endtask

    task automatic test_copy();
        logic [39:0] p;
        p = mk(7'd5, 1'b0, 1'b1, 1'b1, 16'h0F0F);
        req(1'b0, p, "copy");
        recv(exp_out(p, 1'b0), "copy_orig");
        recv(exp_out(p, 1'b1), "copy_dup");
        n_cmp++;
        if (bus.PACKET_OUT[26:20] !== 7'd6 || bus.PACKET_OUT[19] !== 1'b1) begin
            n_err++; $display("FAIL copy_fields: dest %0d lr %b want 6 1",
                              bus.PACKET_OUT[26:20], bus.PACKET_OUT[19]);
        end
        quiet(6, "copy");
        n_cmp++;
        if (copy_cnt !== 16'd1) begin n_err++; $display("FAIL copy_cnt: got %0d want 1", copy_cnt); end
    endtask

    task automatic test_wrap();
        logic [39:0] p;
        p = mk(7'd127, 1'b1, 1'b0, 1'b1, 16'h7777);
        req(1'b0, p, "wrap");
        recv(exp_out(p, 1'b0), "wrap_orig");
        recv(exp_out(p, 1'b1), "wrap_dup");
        n_cmp++;
        if (bus.PACKET_OUT[26:20] !== 7'd0 || bus.PACKET_OUT[19] !== 1'b0) begin
            n_err++; $display("FAIL wrap_fields: dest %0d lr %b want 0 0",
                              bus.PACKET_OUT[26:20], bus.PACKET_OUT[19]);
        end
        n_cmp++;
        if (copy_cnt !== 16'd2) begin n_err++; $display("FAIL wrap_cnt: got %0d want 2", copy_cnt); end
    endtask

    task automatic contend(input bit exp_b, input int r);
        logic [39:0] pa, pb;
        bit first_b;
        int t;
        pa = mk(7'(10 + r), 1'b1, 1'b0, 1'b0, 16'hA000 + 16'(r));
        pb = mk(7'(20 + r), 1'b0, 1'b1, 1'b0, 16'hB000 + 16'(r));
        bus.PACKET_IN_a = pa;
        bus.PACKET_IN_b = pb;
        bus.Send_in_a = 1'b1;
        bus.Send_in_b = 1'b1;
        t = 0;
        do begin tick(); t++; end while (!(bus.Ack_out_a || bus.Ack_out_b) && t < 20);
        first_b = bus.Ack_out_b;
        n_cmp++;
        if (!(bus.Ack_out_a || bus.Ack_out_b) || first_b !== exp_b) begin
            n_err++; $display("FAIL contend%0d grant: got a=%b b=%b want b=%b",
                              r, bus.Ack_out_a, bus.Ack_out_b, exp_b);
        end
        if (first_b) bus.Send_in_b = 1'b0; else bus.Send_in_a = 1'b0;
        t = 0;
        while ((bus.Ack_out_a || bus.Ack_out_b) && t < 20) begin tick(); t++; end
        recv(first_b ? exp_out(pb, 1'b0) : exp_out(pa, 1'b0), "contend_first");
        req(!first_b, first_b ? pa : pb, "contend_second");
        recv(first_b ? exp_out(pa, 1'b0) : exp_out(pb, 1'b0), "contend_second");
    endtask

    task automatic test_contention();
        contend(1'b0, 0);
        contend(1'b1, 1);
        contend(1'b0, 2);
        n_cmp++;
        if (both_seen !== 1'b0) begin n_err++; $display("FAIL both_acks: got 1 want 0"); end
    endtask

    task automatic test_reset_midop();
        logic [39:0] p, p2;
        int t;
        p  = mk(7'd9, 1'b1, 1'b1, 1'b1, 16'h9999);
        p2 = mk(7'd33, 1'b0, 1'b1, 1'b0, 16'h3333);
        req(1'b0, p, "midop");
        t = 0;
        while (bus.Send_out !== 1'b1 && t < 20) begin tick(); t++; end
        MR_N = 1'b0;
        #1;
        n_cmp++;
        if ({bus.Send_out, busy} !== 2'b00 || copy_cnt !== 16'd0) begin
            n_err++; $display("FAIL midop_reset: send %b busy %b cnt %0d want 0 0 0",
                              bus.Send_out, busy, copy_cnt);
        end
        tick();
        MR_N = 1'b1;
        tick();
        req(1'b0, p2, "after_reset");
        recv(exp_out(p2, 1'b0), "after_reset");
        quiet(5, "after_reset");
    endtask

    initial begin
        bus.Send_in_a = 1'b0;
        bus.Send_in_b = 1'b0;
        bus.PACKET_IN_a = '0;
        bus.PACKET_IN_b = '0;
        bus.Ack_in = 1'b0;
        test_reset();
        test_single();
        test_copy();
        test_wrap();
        test_contention();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/copy_sched.md
Name: copy_sched

Overview:
- Clocked copy controller and two-port arbiter in front of the output of the copy path.
- Accepts 40-bit packets from two four-phase Send/Ack requesters (A, B) and grants one at a time, round-robin.
- Latches the granted packet and sequences the output: emits the original packet, then, if the copy flag is set, a second packet with dest+1 and the copy LR flag.
- Produces the 38-bit packet format, with Send/Ack toward the next node.

Parameters:
- DEST_W, 7, destination field width (PKT[28:22]); dest arithmetic is modulo 2^DEST_W.
- CNT_W, 16, width of copy-event counter.

Ports:
- CLK  in  1  system clock, rising edge.
- MR_N  in  1  asynchronous active-low master reset.
- Send_in_a  in  1  requester A send (four-phase).
- PACKET_IN_a  in  40  requester A packet, stable while Send_in_a=1.
- Ack_out_a  out  1  acknowledge to A.
- Send_in_b  in  1  requester B send.
- PACKET_IN_b  in  40  requester B packet.
- Ack_out_b  out  1  acknowledge to B.
- Send_out  out  1  send to next node.
- Ack_in  in  1  acknowledge from next node.
- PACKET_OUT  out  38  output packet, stable while Send_out=1.
- copy_cnt  out  CNT_W  number of copy packets emitted; saturates.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (MR_N=0, async): FSM=IDLE; DL=0; rr pointer=A; copy_phase=0; copy_cnt=0. All outputs 0.
- Fields of DL (latched 40-bit packet):
  - dest=DL[28:22]
  - LRo=DL[21]
  - LRc=DL[20]
  - CPY=DL[18]
- Output merge: PACKET_OUT = {DL[37:27], dsel, lsel, DL[19], DL[17:0]}.
  - Original phase: dsel=dest, lsel=LRo.
  - Copy phase: dsel=dest+1 (mod 2^DEST_W; 127 wraps to 0), lsel=LRc.
- Bits 39 and 38 of the input packet are dropped.
- FSM states: IDLE, ACK_IN, SEND, SEND_RTZ.
  - IDLE: if exactly one Send_in_x=1, grant x. If both are 1, grant the port the rr pointer selects, then flip rr to the other port. On grant, DL<=PACKET_IN_x, copy_phase<=0, go ACK_IN. Ack_out_x=1 from the next cycle.
  - ACK_IN: hold Ack_out_x=1 until Send_in_x=0 is sampled. Then drop Ack_out_x and go SEND. Send_out=1 in the following cycle.
  - SEND: Send_out=1, PACKET_OUT registered and stable. On Ack_in=1, drop Send_out and go SEND_RTZ.
  - SEND_RTZ: wait Ack_in=0.
    - If CPY=1 and copy_phase=0: copy_phase<=1, increment copy_cnt, go SEND.
    - Otherwise go IDLE.
- Minimum latency: Send_in_a rise to Send_out rise is 3 cycles (grant, Ack, Send_in low sampled).
- At most one Ack_out_x is high at any time. The non-granted requester waits with Send held; it is not acknowledged.
- rr pointer updates only on a contested grant. An uncontested grant does not change it.
- Ack_in=1 sampled in IDLE/ACK_IN is ignored; no Send_out is generated.
- Reset mid-operation: immediate return to reset state. Any Send_out in flight drops; a partial packet is discarded.
- copy_cnt saturates at all-ones.
- PACKET_OUT changes only in SEND_RTZ→SEND or IDLE→ACK_IN transitions, never while Send_out=1.

Optional Feature:
- COPY_SCHED_SYNC_EN defined:
  - Send_in_a, Send_in_b and Ack_in pass through 2-flop synchronizers (reset 0) before FSM use.
  - Each handshake edge adds 2 cycles of latency.
  - PACKET_IN_x is sampled at grant; it is stable by the four-phase protocol.
- Undefined: inputs are used directly, for synchronous neighbours.

Decomposition:
- Shared package/header holds:
  - Field position constants: DEST_LSB=22, DEST_MSB=28, LRO_BIT=21, LRC_BIT=20, CPY_BIT=18.
  - PKT_IN_W=40, PKT_OUT_W=38.
  - FSM state encoding.
- One sub-module is natural: copy_sched_rr (two-requester round-robin grant with rr pointer).
- Merge logic stays inline.

Test Plan:
- Reset: MR_N=0 with Send_in_a=1 → all outputs 0. Release → Ack_out_a=1 one cycle after first sampled Send_in_a.
- A sends dest=7'd5, LRo=1, LRc=0, CPY=0 → exactly one output handshake, PACKET_OUT dest=5, LR=1. copy_cnt stays 0.
- A sends CPY=1, dest=5, LRo=0, LRc=1 → two output handshakes: (dest=5, LR=0) then (dest=6, LR=1). copy_cnt=1.
- Wrap: CPY=1, dest=7'd127 → second packet dest=0.
- Contention: A and B raise Send in the same cycle, three times, each with CPY=0 → grants A, B, A. Never both Acks high.
- Reset asserted while Send_out=1 → Send_out=0 immediately. After release, the next A packet is handled normally.
